event_logger: RTL and testbench
===============================

EVENT_LOGGER -- requirements
Module: event_logger

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH_LOG2, default 4, meaning the record FIFO holds 2**FIFO_DEPTH_LOG2 entries.
REQ-002 The block SHALL have parameter MIN_SEVERITY, default 0, meaning the lowest severity that is logged (0=debug, 1=info, 2=warning, 3=error).
REQ-003 clock  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 event_valid  input  1  event strobe, one event per cycle max.
REQ-006 event_severity  input  2  severity of the strobed event.
REQ-007 event_code  input  16  event identifier.
REQ-008 byte_out  output  8  serialized record byte.
REQ-009 byte_valid  output  1  byte_out holds a valid byte.
REQ-010 byte_ready  input  1  downstream accepts byte_out.
REQ-011 dropped_count  output  8  saturating count of events lost to FIFO full.
REQ-012 halted  output  1  sticky flag, set once an error event is accepted.
REQ-013 fifo_empty  output  1  record FIFO holds no entries.

Function
REQ-014 The timestamp SHALL be a free-running 32-bit counter: 0 in the first cycle after reset, +1 per cycle, wrapping from 0xFFFFFFFF to 0.
REQ-015 An event SHALL be eligible when event_valid=1, event_severity>=MIN_SEVERITY and halted=0.
REQ-016 Ineligible events SHALL be ignored and SHALL NOT change dropped_count.
REQ-017 An eligible event SHALL be written to the FIFO as {severity, timestamp of that cycle, code} when the FIFO is not full.
REQ-018 An eligible event arriving with the FIFO full SHALL be discarded and SHALL increment dropped_count, saturating at 255. Full is evaluated before any same-cycle pop.
REQ-019 An accepted event with severity 3 SHALL still be written to the FIFO and SHALL set halted=1 from the next cycle. halted SHALL clear only on reset.
REQ-020 The serializer SHALL emit each record as 8 bytes in this order: 0xA5, {6'b0,severity}, ts[31:24], ts[23:16], ts[15:8], ts[7:0], code[15:8], code[7:0].
REQ-021 The serializer FSM SHALL have two states:
- IDLE: when the FIFO is non-empty, pop one record, load it, set byte index to 0 and go to SEND.
- SEND: byte_valid=1.
REQ-022 In SEND, byte_out SHALL remain stable while byte_valid=1 and byte_ready=0.
REQ-023 A byte is transferred when byte_valid and byte_ready are both 1 on a rising edge. On transfer the index SHALL advance by 1.
REQ-024 On transfer of byte 7, if the FIFO is non-empty the FSM SHALL pop the next record and present its byte 0 in the next cycle with no bubble; otherwise it SHALL return to IDLE with byte_valid=0.
REQ-025 Latency SHALL be: an event accepted in cycle N with the FIFO empty and the FSM in IDLE gives byte_valid=1 with byte_out=0xA5 in cycle N+2.
REQ-026 A push and a pop in the same cycle SHALL both take effect, provided the FIFO is not full before the pop.
REQ-027 fifo_empty SHALL reflect the registered FIFO occupancy.

Reset
REQ-028 While reset=1 at a clock edge, the following SHALL hold in the next cycle:
- byte_valid=0, byte_out=0;
- dropped_count=0, halted=0, fifo_empty=1;
- FSM=IDLE, timestamp=0.
REQ-029 A reset asserted mid-record SHALL abandon the partial record and flush the FIFO. No byte from a pre-reset record SHALL appear after reset.

Verification
REQ-030 Single event: reset, event (sev=1, code=0x1234) at timestamp 5, byte_ready=1 → bytes A5,01,00,00,00,05,12,34 on 8 consecutive cycles, starting 2 cycles after the event.
REQ-031 Backpressure: byte_ready low for 3 cycles during byte 3 → byte_out holds ts[23:16] throughout the stall, and the record completes intact.
REQ-032 Overflow: FIFO_DEPTH_LOG2=4, byte_ready=0, 20 consecutive eligible events → fifo_empty=0, 16 records stored, dropped_count=4. Then 300 further events → dropped_count=255.
REQ-033 Filter/halt: MIN_SEVERITY=2, events with sev 1,2,3,2 → only the sev-2 and sev-3 records are emitted, halted=1 after the sev-3 event, and the trailing sev-2 event is ignored with dropped_count=0.
REQ-034 Back-to-back: two queued records with byte_ready=1 → 16 contiguous valid bytes, with no gap between byte 7 and the next 0xA5.
REQ-035 Mid-record reset: reset pulsed during byte 4 → byte_valid=0 the next cycle, fifo_empty=1, timestamp restarts at 0, and no stale bytes appear afterwards.

Source files
------------

// File: rtl/event_logger_if.sv
// event_logger_if
//   Groups the event strobe and the serialized byte stream of event_logger.
//   event_valid / event_severity / event_code : event input
//   byte_out / byte_valid / byte_ready        : valid/ready byte output
//   slave  : the logger side (consumes events, produces bytes)
//   master : the environment side (produces events, consumes bytes)
interface event_logger_if;
    logic        event_valid;
    logic [1:0]  event_severity;
    logic [15:0] event_code;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready;

    modport slave (
        input  event_valid, event_severity, event_code, byte_ready,
        output byte_out, byte_valid
    );

    modport master (
        output event_valid, event_severity, event_code, byte_ready,
        input  byte_out, byte_valid
    );
endinterface

// File: rtl/event_logger.sv
// event_logger
//   Timestamps eligible events into a record FIFO and serializes each record
//   as 8 bytes: A5, severity, ts[31:24..7:0], code[15:8], code[7:0].
//   clock          : sole clock, rising edge
//   reset          : synchronous, active-high
//   bus (slave)    : event input and valid/ready byte output
//   dropped_count  : saturating count of eligible events lost to FIFO full
//   halted         : sticky, set after an error event is accepted
//   fifo_empty     : record FIFO holds no entries
//
//   state | meaning
//   ------+----------------------------------------------------------
//   IDLE  | no record loaded; pops the FIFO head as soon as one exists
//   SEND  | presenting byte idx of the loaded record, byte_valid=1
module event_logger #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int MIN_SEVERITY    = 0
) (
    input  logic         clock,
    input  logic         reset,
    event_logger_if.slave bus,
    output logic [7:0]   dropped_count,
    output logic         halted,
    output logic         fifo_empty
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    // Bit s set means severity s is logged; avoids a constant comparison
    // when MIN_SEVERITY is 0.
    localparam logic [3:0] SEV_MASK = 4'(4'hF << MIN_SEVERITY);

    typedef enum logic {IDLE, SEND} state_t;

    // Record layout: [49:48] severity, [47:16] timestamp, [15:0] code
    logic [49:0]                mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr;
    logic [FIFO_DEPTH_LOG2:0]   count;
    logic [31:0]                timestamp;
    state_t                     state;
    logic [49:0]                rec;
    logic [2:0]                 idx;
    logic [7:0]                 byte_out_r;
    logic                       byte_valid_r;

    logic fifo_full;
    logic eligible;
    logic push;
    logic pop;
    logic transfer;

    assign bus.byte_out   = byte_out_r;
    assign bus.byte_valid = byte_valid_r;

    // count reaches DEPTH exactly when its top bit is set
    assign fifo_full  = count[FIFO_DEPTH_LOG2];
    assign fifo_empty = (count == '0);
    assign eligible   = bus.event_valid && SEV_MASK[bus.event_severity] && !halted;
    // full is judged on the registered count, so a same-cycle pop does not
    // make room for the incoming event
    assign push       = eligible && !fifo_full;
    assign transfer   = (state == SEND) && bus.byte_ready;
    assign pop        = !fifo_empty && ((state == IDLE) || (transfer && idx == 3'd7));

    function automatic logic [7:0] rec_byte(input logic [49:0] r, input logic [2:0] i);
        case (i)
            3'd0:    rec_byte = 8'hA5;
            3'd1:    rec_byte = {6'b0, r[49:48]};
            3'd2:    rec_byte = r[47:40];
            3'd3:    rec_byte = r[39:32];
            3'd4:    rec_byte = r[31:24];
            3'd5:    rec_byte = r[23:16];
            3'd6:    rec_byte = r[15:8];
            default: rec_byte = r[7:0];
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {bus.event_severity, timestamp, bus.event_code};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            timestamp     <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            dropped_count <= '0;
            halted        <= 1'b0;
            state         <= IDLE;
            rec           <= '0;
            idx           <= '0;
            byte_out_r    <= '0;
            byte_valid_r  <= 1'b0;
        end else begin
            timestamp <= timestamp + 32'd1;

            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (push && bus.event_severity == 2'd3) halted <= 1'b1;
            if (eligible && fifo_full && dropped_count != 8'hFF) begin
                dropped_count <= dropped_count + 8'd1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        rec          <= mem[rd_ptr];
                        idx          <= '0;
                        byte_out_r   <= 8'hA5;
                        byte_valid_r <= 1'b1;
                        state        <= SEND;
                    end
                end
                SEND: begin
                    if (transfer) begin
                        if (idx == 3'd7) begin
                            if (pop) begin
                                // next record follows without a bubble
                                rec        <= mem[rd_ptr];
                                idx        <= '0;
                                byte_out_r <= 8'hA5;
                            end else begin
                                byte_out_r   <= '0;
                                byte_valid_r <= 1'b0;
                                state        <= IDLE;
                            end
                        end else begin
                            idx        <= idx + 3'd1;
                            byte_out_r <= rec_byte(rec, idx + 3'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_event_logger.sv
module tb_event_logger;
    localparam int DEPTH = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ev_valid = 1'b0;
    logic [1:0]  ev_sev = 2'd0;
    logic [15:0] ev_code = 16'd0;
    logic        rdy = 1'b1;
    logic [7:0]  dc0, dc2;
    logic        h0, h2, fe0, fe2;

    always #5 clock = ~clock;

    event_logger_if if0();
    event_logger_if if2();

    assign if0.event_valid    = ev_valid;
    assign if0.event_severity = ev_sev;
    assign if0.event_code     = ev_code;
    assign if0.byte_ready     = rdy;
    assign if2.event_valid    = ev_valid;
    assign if2.event_severity = ev_sev;
    assign if2.event_code     = ev_code;
    assign if2.byte_ready     = rdy;

    event_logger dut0 (
        .clock(clock), .reset(reset), .bus(if0.slave),
        .dropped_count(dc0), .halted(h0), .fifo_empty(fe0)
    );

    event_logger #(.FIFO_DEPTH_LOG2(4), .MIN_SEVERITY(2)) dut2 (
        .clock(clock), .reset(reset), .bus(if2.slave),
        .dropped_count(dc2), .halted(h2), .fifo_empty(fe2)
    );

    // ---------------- reference model ----------------
    int unsigned m_ts;
    int          m_occ [2];
    int          m_left [2];   // bytes of the loaded record still to go, 0 = idle
    int          m_drop [2];
    bit          m_halt [2];
    int          min_sev [2] = '{0, 2};
    logic [7:0]  exp0 [$];
    logic [7:0]  exp1 [$];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_xfer [2];

    function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h, required %0h (cycle %0d)", name, k, act, req, cyc);
        end
    endfunction

    function automatic void push_rec(int k, logic [1:0] s, logic [31:0] t, logic [15:0] c);
        logic [7:0] bs [8];
        bs[0] = 8'hA5;       bs[1] = {6'b0, s};
        bs[2] = t[31:24];    bs[3] = t[23:16];
        bs[4] = t[15:8];     bs[5] = t[7:0];
        bs[6] = c[15:8];     bs[7] = c[7:0];
        for (int i = 0; i < 8; i++) begin
            if (k == 0) exp0.push_back(bs[i]);
            else        exp1.push_back(bs[i]);
        end
    endfunction

    task automatic model_step(input int k);
        bit full, xfer, pop, elig;
        if (reset) begin
            m_occ[k] = 0; m_left[k] = 0; m_drop[k] = 0; m_halt[k] = 0;
            if (k == 0) exp0.delete();
            else        exp1.delete();
        end else begin
            full = (m_occ[k] == DEPTH);
            xfer = (m_left[k] > 0) && rdy;
            pop  = (m_occ[k] > 0) && (m_left[k] == 0 || (xfer && m_left[k] == 1));
            elig = ev_valid && (int'(ev_sev) >= min_sev[k]) && !m_halt[k];
            if (elig && !full) begin
                m_occ[k]++;
                push_rec(k, ev_sev, m_ts, ev_code);
                if (ev_sev == 2'd3) m_halt[k] = 1;
            end else if (elig && m_drop[k] < 255) begin
                m_drop[k]++;
            end
            if (pop) begin
                m_occ[k]--;
                m_left[k] = 8;
            end else if (xfer) begin
                m_left[k]--;
            end
        end
    endtask

    always @(posedge clock) begin
        cyc++;
        for (int k = 0; k < 2; k++) model_step(k);
        if (reset) m_ts = 0;
        else       m_ts = m_ts + 1;
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic mon(input int k);
        logic       bv, h, fe;
        logic [7:0] bo, dc, exp_b;
        bit         have;
        if (k == 0) begin bv = if0.byte_valid; bo = if0.byte_out; dc = dc0; h = h0; fe = fe0; end
        else        begin bv = if2.byte_valid; bo = if2.byte_out; dc = dc2; h = h2; fe = fe2; end
        chk("byte_valid", k, 32'(bv), 32'(m_left[k] > 0));
        if (bv === 1'b1) begin
            have = (k == 0) ? (exp0.size() > 0) : (exp1.size() > 0);
            if (!have) begin
                n_cmp++;
                n_fail++;
                $display("FAIL byte_out dut%0d: got %02h, required no byte (cycle %0d)", k, bo, cyc);
            end else begin
                exp_b = (k == 0) ? exp0[0] : exp1[0];
                chk("byte_out", k, 32'(bo), 32'(exp_b));
                if (rdy) begin
                    if (k == 0) void'(exp0.pop_front());
                    else        void'(exp1.pop_front());
                    n_xfer[k]++;
                end
            end
        end
        chk("dropped_count", k, 32'(dc), 32'(m_drop[k]));
        chk("halted", k, 32'(h), 32'(m_halt[k]));
        chk("fifo_empty", k, 32'(fe), 32'(m_occ[k] == 0));
    endtask

    always @(negedge clock) begin
        if (cyc > 0) begin
            for (int k = 0; k < 2; k++) mon(k);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        ev_valid = 1'b0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("reset_byte_out", 0, 32'(if0.byte_out), 32'h0);
        chk("reset_byte_out", 1, 32'(if2.byte_out), 32'h0);
    endtask

    task automatic send_event(input logic [1:0] s, input logic [15:0] c);
        ev_valid = 1'b1;
        ev_sev   = s;
        ev_code  = c;
        tick();
        ev_valid = 1'b0;
    endtask

    task automatic wait_left0(input int target);
        int i;
        for (i = 0; i < 60; i++) begin
            if (m_left[0] == target) break;
            tick();
        end
        if (i == 60) chk("wait_timeout", 0, 32'd0, 32'd1);
    endtask

    int ev_cyc, first_cyc, run, ts_ev, r;

    initial begin
        // single event at timestamp 5
        rdy = 1'b1;
        do_reset();
        repeat (5) tick();
        ev_cyc = cyc;
        send_event(2'd1, 16'h1234);
        first_cyc = -1;
        for (int i = 0; i < 10; i++) begin
            if (if0.byte_valid) begin first_cyc = cyc; break; end
            tick();
        end
        chk("latency", 0, 32'(first_cyc), 32'(ev_cyc + 2));
        chk("first_byte", 0, 32'(if0.byte_out), 32'hA5);
        repeat (12) tick();

        // backpressure on byte 3
        do_reset();
        repeat (3) tick();
        ts_ev = int'(m_ts);
        send_event(2'd2, 16'hBEEF);
        wait_left0(5);
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_hold", 0, 32'(if0.byte_out), 32'((ts_ev >> 16) & 8'hFF));
            tick();
        end
        rdy = 1'b1;
        repeat (12) tick();

        // overflow: one record stuck in the serializer, then 20 + 300 events
        rdy = 1'b0;
        do_reset();
        send_event(2'd0, 16'h0001);
        tick();
        tick();
        for (int i = 0; i < 20; i++) begin
            ev_valid = 1'b1;
            ev_sev   = 2'($urandom_range(0, 2));
            ev_code  = 16'($urandom);
            tick();
        end
        ev_valid = 1'b0;
        tick();
        chk("overflow_drop", 0, 32'(dc0), 32'd4);
        chk("overflow_nonempty", 0, 32'(fe0), 32'd0);
        for (int i = 0; i < 300; i++) begin
            ev_valid = 1'b1;
            ev_sev   = 2'($urandom_range(0, 2));
            ev_code  = 16'($urandom);
            tick();
        end
        ev_valid = 1'b0;
        tick();
        chk("overflow_saturate", 0, 32'(dc0), 32'd255);
        rdy = 1'b1;
        repeat (17 * 8 + 10) tick();

        // filter / halt
        do_reset();
        n_xfer[0] = 0;
        n_xfer[1] = 0;
        send_event(2'd1, 16'h1111);
        send_event(2'd2, 16'h2222);
        send_event(2'd3, 16'h3333);
        send_event(2'd2, 16'h4444);
        repeat (40) tick();
        chk("filter_bytes", 1, 32'(n_xfer[1]), 32'd16);
        chk("filter_halted", 1, 32'(h2), 32'd1);
        chk("filter_dropped", 1, 32'(dc2), 32'd0);
        chk("halt_bytes", 0, 32'(n_xfer[0]), 32'd24);

        // back-to-back records
        rdy = 1'b0;
        do_reset();
        send_event(2'd2, 16'hAAAA);
        send_event(2'd3, 16'h5555);
        tick();
        rdy = 1'b1;
        run = 0;
        for (int i = 0; i < 30; i++) begin
            if (if0.byte_valid) run++;
            else if (run > 0) break;
            tick();
        end
        chk("contiguous_bytes", 0, 32'(run), 32'd16);
        repeat (4) tick();

        // reset in the middle of a record
        do_reset();
        send_event(2'd2, 16'hC0DE);
        send_event(2'd2, 16'hF00D);
        wait_left0(4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset_valid", 0, 32'(if0.byte_valid), 32'd0);
        chk("midreset_empty", 0, 32'(fe0), 32'd1);
        repeat (3) tick();
        send_event(2'd2, 16'h7777);
        repeat (20) tick();

        // randomized traffic with occasional resets
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rdy      = ($urandom_range(0, 3) != 0);
            ev_valid = $urandom_range(0, 1) == 1;
            r        = int'($urandom_range(0, 99));
            ev_sev   = (r < 2) ? 2'd3 : 2'(r % 3);
            ev_code  = 16'($urandom);
            reset    = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset    = 1'b0;
        ev_valid = 1'b0;
        rdy      = 1'b1;
        repeat (200) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
